// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and responder FSM states
package ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_byte_lane_dec.sv
// ahb_byte_lane_dec: byte strobe and misalignment flag from transfer size and low address bits
module ahb_byte_lane_dec
   import ahb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] strb,
   output logic       misalign
);
   // unsupported sizes get an empty strobe; they are rejected as errors upstream
   always_comb begin
      strb     = (size == HSIZE_BYTE) ? 4'b0001 << addr_lo :
                 (size == HSIZE_HALF) ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                 (size == HSIZE_WORD) ? 4'b1111 : 4'b0000;
      misalign = (size == HSIZE_HALF && addr_lo[0]) || (size == HSIZE_WORD && addr_lo != 2'b00);
   end
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite SRAM responder with wait states and ERROR responses; AHB_SLV_WRITE_PROTECT_EN makes the first PROT_WORDS words read-only
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH       = 256,
   parameter int          WAIT_STATES = 0,
   parameter int          PROT_WORDS  = 16
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Hsel,
   input  logic [31:0] Haddr,
   input  logic [1:0]  Htrans,
   input  logic        Hwrite,
   input  logic [2:0]  Hsize,
   input  logic        Hreadyin,
   input  logic [31:0] Hwdata,
   output logic [31:0] Hrdata,
   output logic        Hreadyout,
   output logic        Hresp
);
   localparam int IW = $clog2(DEPTH);
`ifdef AHB_SLV_WRITE_PROTECT_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   logic [31:0]   mem [DEPTH];
   state_t        state, state_nx;
   logic [IW-1:0] idx_q;
   logic          write_q;
   logic [3:0]    strb_q, strb, cnt;
   logic [31:0]   off;
   logic [IW-1:0] idx;
   logic          misalign, accept, err;

   ahb_byte_lane_dec u_lane (
      .size     (Hsize),
      .addr_lo  (Haddr[1:0]),
      .strb     (strb),
      .misalign (misalign)
   );

   // offset from the window base; wrap-around makes addresses below the base look out of range too
   assign off       = Haddr - BASE_ADDR;
   assign idx       = off[IW+1:2];
   assign Hreadyout = !(state == ST_WAIT || state == ST_ERR1);
   assign Hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
   assign Hrdata    = (state == ST_DATA) ? mem[idx_q] : 32'h0;
   assign accept    = Hsel && Hreadyin && Hreadyout && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);
   assign err       = off >= 32'(4 * DEPTH) || Hsize > HSIZE_WORD || misalign ||
                      (PROT_EN && Hwrite && int'(idx) < PROT_WORDS);

   // next state: WAIT and ERR1 run to completion, every other state may take a new transfer
   always_comb begin
      state_nx = (state == ST_WAIT) ? (cnt == 4'd1 ? ST_DATA : ST_WAIT) :
                 (state == ST_ERR1) ? ST_ERR2 :
                 !accept            ? ST_IDLE :
                 err                ? ST_ERR1 :
                 (WAIT_STATES > 0)  ? ST_WAIT : ST_DATA;
   end

   // state, wait counter and latched address-phase controls
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         strb_q  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= accept ? 4'(WAIT_STATES) : (state == ST_WAIT) ? cnt - 4'd1 : cnt;
         if (accept) begin
            idx_q   <= idx;
            write_q <= Hwrite;
            strb_q  <= strb;
         end
      end
   end

   // write commits on the edge that ends DATA; reset forces IDLE so an aborted write never lands
   always_ff @(posedge Hclk) begin
      if (state == ST_DATA && write_q)
         for (int b = 0; b < 4; b++)
            if (strb_q[b]) mem[idx_q][8*b +: 8] <= Hwdata[8*b +: 8];
   end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed checks of ahb_slave_mem over zero-wait, wait-state and write-protect instances
module tb_ahb_slave_mem;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wdata;
   logic [1:0]  trans;
   logic        write, hold;
   logic [2:0]  size;
   logic        sel0, sel2, sel3, sel4;
   logic [31:0] rd0, rd2, rd3, rd4, rdata;
   logic        ro0, ro2, ro3, ro4, rs0, rs2, rs3, rs4, ready, resp;
   int          dsel;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] rd;
   logic        fr, lr;
   int          waits;
   logic [31:0] burst_exp [4];

   always #5 clk = ~clk;

   assign rdata = dsel == 2 ? rd2 : dsel == 3 ? rd3 : dsel == 4 ? rd4 : rd0;
   assign ready = dsel == 2 ? ro2 : dsel == 3 ? ro3 : dsel == 4 ? ro4 : ro0;
   assign resp  = dsel == 2 ? rs2 : dsel == 3 ? rs3 : dsel == 4 ? rs4 : rs0;

   ahb_slave_mem #(.WAIT_STATES(0), .PROT_WORDS(0)) u_ws0 (
      .Hclk(clk), .Hresetn(rst_n), .Hsel(sel0), .Haddr(addr), .Htrans(trans), .Hwrite(write),
      .Hsize(size), .Hreadyin(ro0 & ~hold), .Hwdata(wdata), .Hrdata(rd0), .Hreadyout(ro0), .Hresp(rs0));
   ahb_slave_mem #(.WAIT_STATES(2), .PROT_WORDS(0)) u_ws2 (
      .Hclk(clk), .Hresetn(rst_n), .Hsel(sel2), .Haddr(addr), .Htrans(trans), .Hwrite(write),
      .Hsize(size), .Hreadyin(ro2), .Hwdata(wdata), .Hrdata(rd2), .Hreadyout(ro2), .Hresp(rs2));
   ahb_slave_mem #(.WAIT_STATES(3), .PROT_WORDS(0)) u_ws3 (
      .Hclk(clk), .Hresetn(rst_n), .Hsel(sel3), .Haddr(addr), .Htrans(trans), .Hwrite(write),
      .Hsize(size), .Hreadyin(ro3), .Hwdata(wdata), .Hrdata(rd3), .Hreadyout(ro3), .Hresp(rs3));
   ahb_slave_mem u_wp (
      .Hclk(clk), .Hresetn(rst_n), .Hsel(sel4), .Haddr(addr), .Htrans(trans), .Hwrite(write),
      .Hsize(size), .Hreadyin(ro4), .Hwdata(wdata), .Hrdata(rd4), .Hreadyout(ro4), .Hresp(rs4));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic addr_ph(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] t);
      dsel = d; sel0 = (d == 0); sel2 = (d == 2); sel3 = (d == 3); sel4 = (d == 4);
      addr = a; write = w; size = sz; trans = t;
   endtask

   task automatic idle_bus();
      sel0 = 1'b0; sel2 = 1'b0; sel3 = 1'b0; sel4 = 1'b0; trans = 2'b00;
   endtask

   // one NONSEQ transfer; returns read data and response at the completing cycle
   task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                       output logic [31:0] r, output logic first_resp, output logic last_resp, output int nw);
      @(negedge clk);
      addr_ph(d, a, w, sz, 2'b10);
      @(negedge clk);
      idle_bus();
      wdata = wd;
      first_resp = resp;
      nw = 0;
      while (!ready && nw < 40) begin
         nw++;
         @(negedge clk);
      end
      r = rdata;
      last_resp = resp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; hold = 1'b0; dsel = 0; addr = '0; wdata = '0; write = 1'b0; size = 3'b000;
      idle_bus();
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_resp", 32'(resp), 32'd0);
      check("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      xfer(0, 32'h8000_0000, 1'b1, 3'b010, 32'h0, rd, fr, lr, waits);
      xfer(0, 32'h8000_0001, 1'b1, 3'b000, 32'h0000_8000, rd, fr, lr, waits);
      check("byte_wr_resp", 32'(lr), 32'd0);
      xfer(0, 32'h8000_0000, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("byte_rd_data", rd, 32'h0000_8000);
      check("byte_rd_waits", 32'(waits), 32'd0);

      xfer(0, 32'h8000_03FC, 1'b1, 3'b010, 32'hCAFE_0003, rd, fr, lr, waits);
      check("top_wr_resp", 32'(lr), 32'd0);
      xfer(0, 32'h8000_03FC, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("top_rd_data", rd, 32'hCAFE_0003);

      xfer(0, 32'h8000_0048, 1'b1, 3'b010, 32'hBEEF_CAFE, rd, fr, lr, waits);
      xfer(0, 32'h8000_004C, 1'b1, 3'b010, 32'h1234_5678, rd, fr, lr, waits);
      burst_exp = '{32'hBEEF_CAFE, 32'hBEEF_CAFE, 32'h1234_5678, 32'h1234_5678};
      @(negedge clk);
      addr_ph(0, 32'h8000_0048, 1'b0, 3'b001, 2'b10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) addr_ph(0, 32'h8000_0048 + 32'(2 * (i + 1)), 1'b0, 3'b001, 2'b11);
         else idle_bus();
         check($sformatf("burst%0d_ready", i), 32'(ready), 32'd1);
         check($sformatf("burst%0d_resp", i), 32'(resp), 32'd0);
         check($sformatf("burst%0d_data", i), rdata, burst_exp[i]);
      end

      xfer(0, 32'h8000_0400, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("oor_err1_resp", 32'(fr), 32'd1);
      check("oor_err1_len", 32'(waits), 32'd1);
      check("oor_err2_resp", 32'(lr), 32'd1);
      xfer(0, 32'h8000_0003, 1'b1, 3'b001, 32'hFFFF_FFFF, rd, fr, lr, waits);
      check("mis_err1_resp", 32'(fr), 32'd1);
      check("mis_err1_len", 32'(waits), 32'd1);
      check("mis_err2_resp", 32'(lr), 32'd1);
      xfer(0, 32'h8000_0000, 1'b1, 3'b011, 32'hFFFF_FFFF, rd, fr, lr, waits);
      check("size_err_resp", 32'(lr), 32'd1);
      xfer(0, 32'h7FFF_FFFC, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("below_err_resp", 32'(lr), 32'd1);
      xfer(0, 32'h8000_0000, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("err_mem_kept", rd, 32'h0000_8000);

      hold = 1'b1;
      @(negedge clk);
      addr_ph(0, 32'h8000_0000, 1'b1, 3'b010, 2'b10);
      @(negedge clk);
      idle_bus();
      wdata = 32'hFFFF_FFFF;
      check("hold_no_data_phase", rdata, 32'h0);
      hold = 1'b0;
      xfer(0, 32'h8000_0000, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("hold_mem_kept", rd, 32'h0000_8000);

      xfer(2, 32'h8000_0010, 1'b1, 3'b010, 32'hA5A5_0001, rd, fr, lr, waits);
      check("ws2_wr_waits", 32'(waits), 32'd2);
      xfer(2, 32'h8000_0010, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("ws2_rd_waits", 32'(waits), 32'd2);
      check("ws2_rd_data", rd, 32'hA5A5_0001);
      check("ws2_rd_resp", 32'(lr), 32'd0);

      xfer(3, 32'h8000_0020, 1'b1, 3'b010, 32'h1111_2222, rd, fr, lr, waits);
      @(negedge clk);
      addr_ph(3, 32'h8000_0020, 1'b1, 3'b010, 2'b10);
      @(negedge clk);
      idle_bus();
      wdata = 32'hDEAD_BEEF;
      check("ws3_in_wait", 32'(ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_abort_ready", 32'(ready), 32'd1);
      check("rst_abort_resp", 32'(resp), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(3, 32'h8000_0020, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("rst_abort_mem", rd, 32'h1111_2222);
      check("ws3_rd_waits", 32'(waits), 32'd3);

      xfer(4, 32'h8000_0040, 1'b1, 3'b010, 32'h0BAD_F00D, rd, fr, lr, waits);
      check("wp_open_wr_resp", 32'(lr), 32'd0);
      xfer(4, 32'h8000_0040, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("wp_open_rd_data", rd, 32'h0BAD_F00D);
      xfer(4, 32'h8000_0004, 1'b1, 3'b010, 32'h5A5A_C3C3, rd, fr, lr, waits);
`ifdef AHB_SLV_WRITE_PROTECT_EN
      check("wp_prot_err1", 32'(fr), 32'd1);
      check("wp_prot_err2", 32'(lr), 32'd1);
      xfer(4, 32'h8000_0004, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("wp_prot_rd_resp", 32'(lr), 32'd0);
`else
      check("wp_off_wr_resp", 32'(lr), 32'd0);
      xfer(4, 32'h8000_0004, 1'b0, 3'b010, 32'h0, rd, fr, lr, waits);
      check("wp_off_rd_data", rd, 32'h5A5A_C3C3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite responder: the target end of the AHB master transactions the team drives into the bridge.
- Exposes a word-addressed SRAM window at BASE_ADDR.
- Supports programmable wait states, byte/halfword/word sizes, and two-cycle ERROR responses.
- Serves as a standalone bus endpoint and as the AHB-side model for bridge verification.

Parameters:
BASE_ADDR, 32'h8000_0000, first byte address of the window
DEPTH, 256, number of 32-bit words (power of two)
WAIT_STATES, 0, Hreadyout-low cycles inserted per OKAY data phase (0..15)
PROT_WORDS, 16, size in words of the write-protected region at window start (used only with the optional feature)

Ports:
Hclk  input  1  clock; all state updates on rising edge
Hresetn  input  1  asynchronous active-low reset
Hsel  input  1  slave select
Haddr  input  32  address-phase address
Htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
Hwrite  input  1  1=write, 0=read
Hsize  input  3  000 byte, 001 half, 010 word
Hreadyin  input  1  bus-level HREADY
Hwdata  input  32  write data, valid in data phase
Hrdata  output  32  read data
Hreadyout  output  1  data-phase completion
Hresp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset: Hreadyout=1, Hresp=0, Hrdata=0, FSM=IDLE, address/control registers cleared. Memory contents are not reset. Reset asserted mid-transfer aborts it immediately; a pending write is not committed.
- Transfer accept: Hsel & Hreadyin & Htrans[1] at a rising edge. The edge latches Haddr, Hwrite, Hsize and the byte strobe, and starts a data phase.
- Non-transfers: IDLE/BUSY, or Hsel=0 with Hreadyin=1, produce no data phase. Response is zero-wait OKAY (Hreadyout=1, Hresp=0).
- Error check, evaluated at accept: the transfer gets ERROR when any of these holds:
  - address outside BASE_ADDR..BASE_ADDR+4*DEPTH-1;
  - Hsize>010;
  - misaligned (half with Haddr[0]=1, or word with Haddr[1:0]!=0).
- FSM states:
  - IDLE: Hreadyout=1, Hresp=0. On accept goes to WAIT if WAIT_STATES>0, else DATA; goes to ERR1 on error.
  - WAIT: Hreadyout=0. Down-counter loaded with WAIT_STATES at accept; goes to DATA when the counter reaches 1.
  - DATA: Hreadyout=1, Hresp=0. Completes the transfer. Re-accept from DATA is legal, so back-to-back pipelined transfers run with zero bubbles when WAIT_STATES=0. With no new accept, returns to IDLE.
  - ERR1: Hreadyout=0, Hresp=1; goes to ERR2 unconditionally.
  - ERR2: Hreadyout=1, Hresp=1. May accept a new transfer; otherwise returns to IDLE.
- Write commit: at the rising edge ending DATA, Hwdata bytes selected by the strobe are written to mem[addr_q[log2(DEPTH)+1:2]]. Errored transfers never write.
- Read: in DATA, Hrdata = mem[word index] combinationally, with full word lanes (unselected bytes unmasked). Outside DATA, Hrdata=0.
- Same-word read immediately after a write sees the new data, because the write commits at the edge that starts the read's data phase.
- Address phases arriving while Hreadyin=0 are ignored. Master-held values are re-sampled when Hreadyin returns high.

Optional Feature:
AHB_SLV_WRITE_PROTECT_EN
- Defined: a write whose word index is < PROT_WORDS is flagged as an error at accept and takes the ERR1/ERR2 path; memory is unchanged. Reads to that region remain OKAY.
- Undefined: the whole window is writable and PROT_WORDS is unused.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/ERROR;
  - the FSM state enum {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2}.
- One sub-module, ahb_byte_lane_dec: inputs Hsize and Haddr[1:0]; outputs a 4-bit strobe and a misalign flag. Purely combinational.

Test Plan:
- Byte write then read: NONSEQ write, Hsize=000, 8000_0001, Hwdata=32'h0000_8000 (byte 0x80 on lane 1); then read at 8000_0000, word size → OKAY, Hrdata=32'h0000_8000 given prior word=0.
- Wait states: WAIT_STATES=2, word read at 8000_0010 → Hreadyout low exactly 2 cycles, then high with data.
- Pipelined burst: INCR4 halfword reads at 8000_0048/4A/4C/4E after writing word 0x48=32'hBEEF_CAFE and word 0x4C=32'h1234_5678 → four consecutive zero-wait DATA cycles. Hrdata shows each word's full contents: 32'hBEEF_CAFE for 48 and 4A, 32'h1234_5678 for 4C and 4E.
- Error: read at 8000_0400 (out of range), then a halfword at 8000_0003 → each gives ERR1 (Hreadyout=0, Hresp=1) then ERR2 (Hreadyout=1, Hresp=1); memory unchanged.
- Reset mid-phase: WAIT_STATES=3 write, Hresetn low during WAIT → Hreadyout=1, Hresp=0 at once, target word keeps its old value.
- With AHB_SLV_WRITE_PROTECT_EN: word write to 8000_0004 → ERROR and readback unchanged; the same write to 8000_0040 → OKAY.
